// File: rtl/ex_if.sv
// ex_if: bundle of the ID/EX-side inputs and EX/MEM-side outputs of the
// execute stage.
//   slave  modport: used by ex_stage (consumes ID/EX fields, drives EX/MEM fields)
//   master modport: used by the upstream/downstream environment
// Inputs : hit, readDataOne, readDataTwo, immediate, registerDestination,
//          ALUSource, memToReg, regWrite, memRead, memWrite, branch,
//          ALUOperation, RT, RD, Function, nextPC
// Outputs: ALUResultOut, writeDataOut, writeRegisterOut, branchTargetOut,
//          zeroOut, memToRegOut, regWriteOut, memReadOut, memWriteOut,
//          branchOut, hitOut, stallOut
interface ex_if #(
    parameter int WIDTH          = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      hit;
    logic [WIDTH-1:0]          readDataOne;
    logic [WIDTH-1:0]          readDataTwo;
    logic [WIDTH-1:0]          immediate;
    logic                      registerDestination;
    logic                      ALUSource;
    logic                      memToReg;
    logic                      regWrite;
    logic                      memRead;
    logic                      memWrite;
    logic                      branch;
    logic [2:0]                ALUOperation;
    logic [REG_ADDR_WIDTH-1:0] RT;
    logic [REG_ADDR_WIDTH-1:0] RD;
    logic [5:0]                Function;
    logic [WIDTH-1:0]          nextPC;

    logic [WIDTH-1:0]          ALUResultOut;
    logic [WIDTH-1:0]          writeDataOut;
    logic [REG_ADDR_WIDTH-1:0] writeRegisterOut;
    logic [WIDTH-1:0]          branchTargetOut;
    logic                      zeroOut;
    logic                      memToRegOut;
    logic                      regWriteOut;
    logic                      memReadOut;
    logic                      memWriteOut;
    logic                      branchOut;
    logic                      hitOut;
    logic                      stallOut;

    modport slave (
        input  hit, readDataOne, readDataTwo, immediate, registerDestination,
               ALUSource, memToReg, regWrite, memRead, memWrite, branch,
               ALUOperation, RT, RD, Function, nextPC,
        output ALUResultOut, writeDataOut, writeRegisterOut, branchTargetOut,
               zeroOut, memToRegOut, regWriteOut, memReadOut, memWriteOut,
               branchOut, hitOut, stallOut
    );

    modport master (
        output hit, readDataOne, readDataTwo, immediate, registerDestination,
               ALUSource, memToReg, regWrite, memRead, memWrite, branch,
               ALUOperation, RT, RD, Function, nextPC,
        input  ALUResultOut, writeDataOut, writeRegisterOut, branchTargetOut,
               zeroOut, memToRegOut, regWriteOut, memReadOut, memWriteOut,
               branchOut, hitOut, stallOut
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage plus EX/MEM pipeline register.
//   clock : sole clock, rising edge
//   reset : asynchronous, active-high; clears all state and outputs
//   bus   : ex_if.slave -- ID/EX fields in, registered EX/MEM fields out,
//           combinational stallOut asking ID/EX to hold.
// Single-cycle ALU ops complete in one clock. R-type mult runs an iterative
// shift-add multiplier (1 entry clock + WIDTH step clocks) during which the
// EX/MEM register is fed bubbles.
module ex_stage #(
    parameter int WIDTH          = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic clock,
    input  logic reset,
    ex_if.slave  bus
);
    localparam int                CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, MUL = 1'b1} state_t;
    typedef enum logic [2:0] {ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2,
                              ALU_OR  = 3'd3, ALU_SLT = 3'd4} alu_ctl_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [WIDTH-1:0]           mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [WIDTH-1:0]           result_q, result_d, wdata_q, wdata_d, btarget_q, btarget_d;
    logic [REG_ADDR_WIDTH-1:0]  wreg_q, wreg_d;
    logic                       zero_q, zero_d, hit_q, hit_d;
    logic                       mem_to_reg_q, mem_to_reg_d, reg_write_q, reg_write_d;
    logic                       mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic                       branch_q, branch_d;

    alu_ctl_t                   alu_ctl_s;
    logic                       is_mult_s, stall_s, load_s, bubble_s;
    logic [WIDTH-1:0]           operand_b_s, alu_result_s, product_s, final_s;

    // Decode ALU operation and recognise the multi-cycle mult.
    always_comb begin
        alu_ctl_s = ALU_ADD;
        is_mult_s = 1'b0;
        case (bus.ALUOperation)
            3'b000: alu_ctl_s = ALU_ADD;
            3'b001: alu_ctl_s = ALU_SUB;
            3'b010: begin
                case (bus.Function)
                    6'b100000: alu_ctl_s = ALU_ADD;
                    6'b100010: alu_ctl_s = ALU_SUB;
                    6'b100100: alu_ctl_s = ALU_AND;
                    6'b100101: alu_ctl_s = ALU_OR;
                    6'b101010: alu_ctl_s = ALU_SLT;
                    6'b011000: is_mult_s = 1'b1;
                    default:   alu_ctl_s = ALU_ADD;
                endcase
            end
            3'b011:  alu_ctl_s = ALU_AND;
            3'b100:  alu_ctl_s = ALU_OR;
            3'b101:  alu_ctl_s = ALU_SLT;
            default: alu_ctl_s = ALU_ADD;
        endcase
    end

    // Operand B select and single-cycle ALU; R-type always uses readDataTwo.
    always_comb begin
        operand_b_s = bus.readDataTwo;
        if (bus.ALUOperation != 3'b010 && bus.ALUSource) begin
            operand_b_s = bus.immediate;
        end else begin
            operand_b_s = bus.readDataTwo;
        end
        case (alu_ctl_s)
            ALU_ADD: alu_result_s = bus.readDataOne + operand_b_s;
            ALU_SUB: alu_result_s = bus.readDataOne - operand_b_s;
            ALU_AND: alu_result_s = bus.readDataOne & operand_b_s;
            ALU_OR:  alu_result_s = bus.readDataOne | operand_b_s;
            ALU_SLT: alu_result_s = {{(WIDTH-1){1'b0}},
                                     ($signed(bus.readDataOne) < $signed(operand_b_s))};
            default: alu_result_s = bus.readDataOne + operand_b_s;
        endcase
    end

    // One shift-add step; on the last step this is the finished product.
    assign product_s = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});
    assign final_s   = (state_q == MUL) ? product_s : alu_result_s;

    // Stall request: forced low while reset is held so upstream never freezes on reset.
    always_comb begin
        stall_s = 1'b0;
        if (reset) begin
            stall_s = 1'b0;
        end else begin
            case (state_q)
                IDLE:    stall_s = is_mult_s;
                MUL:     stall_s = (count_q != LAST_STEP);
                default: stall_s = 1'b0;
            endcase
        end
    end

    // FSM next state and multiplier datapath; nothing moves while hit is low.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        load_s   = 1'b0;
        bubble_s = 1'b0;
        if (bus.hit) begin
            case (state_q)
                IDLE: begin
                    if (is_mult_s) begin
                        mcand_d  = bus.readDataOne;
                        mplier_d = bus.readDataTwo;
                        acc_d    = {WIDTH{1'b0}};
                        count_d  = {CNT_W{1'b0}};
                        state_d  = MUL;
                        bubble_s = 1'b1;
                    end else begin
                        load_s   = 1'b1;
                    end
                end
                MUL: begin
                    acc_d    = product_s;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    if (count_q == LAST_STEP) begin
                        count_d = {CNT_W{1'b0}};
                        state_d = IDLE;
                        load_s  = 1'b1;
                    end else begin
                        count_d  = count_q + CNT_W'(1);
                        bubble_s = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // EX/MEM register next values: new instruction, bubble (controls cleared, data held) or hold.
    always_comb begin
        result_d     = result_q;
        wdata_d      = wdata_q;
        btarget_d    = btarget_q;
        wreg_d       = wreg_q;
        zero_d       = zero_q;
        mem_to_reg_d = mem_to_reg_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        branch_d     = branch_q;
        hit_d        = bus.hit;
        if (load_s) begin
            result_d     = final_s;
            zero_d       = (final_s == {WIDTH{1'b0}});
            wdata_d      = bus.readDataTwo;
            btarget_d    = bus.nextPC + {bus.immediate[WIDTH-3:0], 2'b00};
            wreg_d       = bus.registerDestination ? bus.RD : bus.RT;
            mem_to_reg_d = bus.memToReg;
            reg_write_d  = bus.regWrite;
            mem_read_d   = bus.memRead;
            mem_write_d  = bus.memWrite;
            branch_d     = bus.branch;
        end else if (bubble_s) begin
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            branch_d     = 1'b0;
        end else begin
            result_d     = result_q;
        end
    end

    // State, multiplier and EX/MEM registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= {CNT_W{1'b0}};
            mcand_q      <= {WIDTH{1'b0}};
            mplier_q     <= {WIDTH{1'b0}};
            acc_q        <= {WIDTH{1'b0}};
            result_q     <= {WIDTH{1'b0}};
            wdata_q      <= {WIDTH{1'b0}};
            btarget_q    <= {WIDTH{1'b0}};
            wreg_q       <= {REG_ADDR_WIDTH{1'b0}};
            zero_q       <= 1'b0;
            hit_q        <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            branch_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            acc_q        <= acc_d;
            result_q     <= result_d;
            wdata_q      <= wdata_d;
            btarget_q    <= btarget_d;
            wreg_q       <= wreg_d;
            zero_q       <= zero_d;
            hit_q        <= hit_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            branch_q     <= branch_d;
        end
    end

    assign bus.ALUResultOut     = result_q;
    assign bus.writeDataOut     = wdata_q;
    assign bus.writeRegisterOut = wreg_q;
    assign bus.branchTargetOut  = btarget_q;
    assign bus.zeroOut          = zero_q;
    assign bus.memToRegOut      = mem_to_reg_q;
    assign bus.regWriteOut      = reg_write_q;
    assign bus.memReadOut       = mem_read_q;
    assign bus.memWriteOut      = mem_write_q;
    assign bus.branchOut        = branch_q;
    assign bus.hitOut           = hit_q;
    assign bus.stallOut         = stall_s;
endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
    localparam int W  = 32;
    localparam int RW = 5;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ex_if #(.WIDTH(W), .REG_ADDR_WIDTH(RW)) bus();
    ex_stage #(.WIDTH(W), .REG_ADDR_WIDTH(RW)) dut (.clock(clock), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [5:0]  fn;
        logic        src;
        logic        rdst;
        logic [31:0] a, b, imm, npc;
        logic [4:0]  rt, rd;
        logic [4:0]  ctrl;      // {memToReg, regWrite, memRead, memWrite, branch}
        logic [31:0] exp_res;
        logic        exp_zero;
        logic [31:0] exp_bt;
        logic [4:0]  exp_wr;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] ctrl_out();
        return {bus.memToRegOut, bus.regWriteOut, bus.memReadOut, bus.memWriteOut, bus.branchOut};
    endfunction

    task automatic drive(input vec_t v);
        bus.ALUOperation        = v.op;
        bus.Function            = v.fn;
        bus.ALUSource           = v.src;
        bus.registerDestination = v.rdst;
        bus.readDataOne         = v.a;
        bus.readDataTwo         = v.b;
        bus.immediate           = v.imm;
        bus.nextPC              = v.npc;
        bus.RT                  = v.rt;
        bus.RD                  = v.rd;
        {bus.memToReg, bus.regWrite, bus.memRead, bus.memWrite, bus.branch} = v.ctrl;
    endtask

    task automatic drive_mult(input logic [31:0] a, input logic [31:0] b);
        bus.ALUOperation        = 3'b010;
        bus.Function            = 6'b011000;
        bus.ALUSource           = 1'b1;
        bus.immediate           = 32'd999;
        bus.registerDestination = 1'b1;
        bus.RD                  = 5'd5;
        bus.RT                  = 5'd6;
        bus.readDataOne         = a;
        bus.readDataTwo         = b;
        bus.nextPC              = 32'd0;
        {bus.memToReg, bus.regWrite, bus.memRead, bus.memWrite, bus.branch} = 5'b01000;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_res"},   bus.ALUResultOut, 32'd0);
        chk({tag, "_wdata"}, bus.writeDataOut, 32'd0);
        chk({tag, "_wreg"},  32'(bus.writeRegisterOut), 32'd0);
        chk({tag, "_bt"},    bus.branchTargetOut, 32'd0);
        chk({tag, "_zero"},  32'(bus.zeroOut), 32'd0);
        chk({tag, "_ctrl"},  32'(ctrl_out()), 32'd0);
        chk({tag, "_hit"},   32'(bus.hitOut), 32'd0);
        chk({tag, "_stall"}, 32'(bus.stallOut), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] snap_res, snap_bt, snap_wd;
        logic [4:0]  snap_wr, snap_ctrl;
        logic        snap_zero, done;
        int          stall_cycles, edges;

        //           op      fn         src   rdst  a             b             imm           npc           rt     rd     ctrl      exp_res       z     exp_bt        exp_wr
        vecs[0]  = '{3'b010, 6'b100000, 1'b0, 1'b1, 32'd2,        32'd17,       32'd0,        32'd0,        5'd3,  5'd10, 5'b01000, 32'd19,       1'b0, 32'd0,        5'd10};
        vecs[1]  = '{3'b001, 6'b000000, 1'b1, 1'b0, 32'd15,       32'd99,       32'd15,       32'd3,        5'd7,  5'd9,  5'b00001, 32'd0,        1'b1, 32'd63,       5'd7};
        vecs[2]  = '{3'b010, 6'b100010, 1'b0, 1'b1, 32'd5,        32'd7,        32'd0,        32'd0,        5'd1,  5'd2,  5'b01000, 32'hFFFFFFFE, 1'b0, 32'd0,        5'd2};
        vecs[3]  = '{3'b011, 6'b000000, 1'b0, 1'b0, 32'h0000F0F0, 32'h0000FF00, 32'd0,        32'd0,        5'd4,  5'd6,  5'b00000, 32'h0000F000, 1'b0, 32'd0,        5'd4};
        vecs[4]  = '{3'b100, 6'b000000, 1'b1, 1'b0, 32'h000000F0, 32'h12345678, 32'h0000000F, 32'h00000100, 5'd8,  5'd9,  5'b00010, 32'h000000FF, 1'b0, 32'h0000013C, 5'd8};
        vecs[5]  = '{3'b101, 6'b000000, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        5'd3,  5'd11, 5'b01000, 32'd1,        1'b0, 32'd0,        5'd11};
        vecs[6]  = '{3'b010, 6'b101010, 1'b0, 1'b1, 32'd5,        32'hFFFFFFFD, 32'd0,        32'd0,        5'd3,  5'd12, 5'b01000, 32'd0,        1'b1, 32'd0,        5'd12};
        vecs[7]  = '{3'b110, 6'b000000, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        5'd13, 5'd14, 5'b10100, 32'd0,        1'b1, 32'd0,        5'd13};
        vecs[8]  = '{3'b111, 6'b000000, 1'b1, 1'b0, 32'd10,       32'd0,        32'd20,       32'h00000020, 5'd15, 5'd16, 5'b00000, 32'd30,       1'b0, 32'h00000070, 5'd15};
        vecs[9]  = '{3'b010, 6'b000111, 1'b0, 1'b1, 32'd10,       32'd20,       32'd0,        32'd0,        5'd1,  5'd17, 5'b01000, 32'd30,       1'b0, 32'd0,        5'd17};
        vecs[10] = '{3'b010, 6'b100000, 1'b1, 1'b1, 32'd1,        32'd2,        32'd100,      32'd0,        5'd1,  5'd18, 5'b01000, 32'd3,        1'b0, 32'd400,      5'd18};
        vecs[11] = '{3'b010, 6'b100100, 1'b0, 1'b0, 32'h0000000C, 32'h0000000A, 32'd0,        32'd0,        5'd19, 5'd20, 5'b01000, 32'h00000008, 1'b0, 32'd0,        5'd19};
        vecs[12] = '{3'b010, 6'b100101, 1'b0, 1'b0, 32'h0000000C, 32'h0000000A, 32'd2,        32'hFFFFFFFC, 5'd21, 5'd22, 5'b01000, 32'h0000000E, 1'b0, 32'h00000004, 5'd21};
        vecs[13] = '{3'b000, 6'b000000, 1'b0, 1'b0, 32'd3,        32'd4,        32'hFFFFFFFF, 32'h00000010, 5'd23, 5'd24, 5'b00001, 32'd7,        1'b0, 32'h0000000C, 5'd23};

        // Reset state
        reset   = 1'b1;
        bus.hit = 1'b0;
        drive(vecs[3]);
        #12;
        check_zero("reset");
        @(negedge clock);
        reset   = 1'b0;
        bus.hit = 1'b1;

        // Single-cycle vectors
        for (int i = 0; i < $size(vecs); i++) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_stall", i), 32'(bus.stallOut), 32'd0);
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_res", i),   bus.ALUResultOut, vecs[i].exp_res);
            chk($sformatf("v%0d_zero", i),  32'(bus.zeroOut), 32'(vecs[i].exp_zero));
            chk($sformatf("v%0d_bt", i),    bus.branchTargetOut, vecs[i].exp_bt);
            chk($sformatf("v%0d_wreg", i),  32'(bus.writeRegisterOut), 32'(vecs[i].exp_wr));
            chk($sformatf("v%0d_wdata", i), bus.writeDataOut, vecs[i].b);
            chk($sformatf("v%0d_ctrl", i),  32'(ctrl_out()), 32'(vecs[i].ctrl));
            chk($sformatf("v%0d_hit", i),   32'(bus.hitOut), 32'd1);
        end

        // Frozen pipeline: hit low for 5 cycles with changing inputs
        snap_res  = bus.ALUResultOut;
        snap_bt   = bus.branchTargetOut;
        snap_wd   = bus.writeDataOut;
        snap_wr   = bus.writeRegisterOut;
        snap_ctrl = ctrl_out();
        snap_zero = bus.zeroOut;
        for (int k = 0; k < 5; k++) begin
            drive(vecs[k]);
            bus.hit = 1'b0;
            @(posedge clock);
            #1;
            chk($sformatf("hold%0d_res", k),   bus.ALUResultOut, snap_res);
            chk($sformatf("hold%0d_bt", k),    bus.branchTargetOut, snap_bt);
            chk($sformatf("hold%0d_wdata", k), bus.writeDataOut, snap_wd);
            chk($sformatf("hold%0d_wreg", k),  32'(bus.writeRegisterOut), 32'(snap_wr));
            chk($sformatf("hold%0d_ctrl", k),  32'(ctrl_out()), 32'(snap_ctrl));
            chk($sformatf("hold%0d_zero", k),  32'(bus.zeroOut), 32'(snap_zero));
            chk($sformatf("hold%0d_hitout", k), 32'(bus.hitOut), 32'd0);
        end
        bus.hit = 1'b1;
        drive(vecs[0]);
        @(posedge clock);
        #1;
        chk("resume_hitout", 32'(bus.hitOut), 32'd1);
        chk("resume_res", bus.ALUResultOut, 32'd19);

        // Asynchronous reset mid-stream
        drive(vecs[1]);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check_zero("async_rst");
        @(negedge clock);
        reset = 1'b0;

        // Mult 23 * 10
        drive_mult(32'd23, 32'd10);
        stall_cycles = 0;
        for (int c = 1; c <= 33; c++) begin
            #1;
            if (bus.stallOut) stall_cycles++;
            @(posedge clock);
            #1;
            if (c <= 32) chk($sformatf("mul_bubble%0d", c), 32'(bus.regWriteOut), 32'd0);
        end
        chk("mul_stall_cycles", 32'(stall_cycles), 32'd32);
        chk("mul_res", bus.ALUResultOut, 32'd230);
        chk("mul_regwrite", 32'(bus.regWriteOut), 32'd1);
        chk("mul_wreg", 32'(bus.writeRegisterOut), 32'd5);
        chk("mul_zero", 32'(bus.zeroOut), 32'd0);

        // Mult 0xFFFFFFFF * 2 with hit low for 3 cycles in the middle
        drive_mult(32'hFFFFFFFF, 32'd2);
        edges = 0;
        done  = 1'b0;
        for (int c = 1; c <= 60 && !done; c++) begin
            bus.hit = (c >= 11 && c <= 13) ? 1'b0 : 1'b1;
            #1;
            if (bus.hit && !bus.stallOut) done = 1'b1;
            @(posedge clock);
            #1;
            edges++;
        end
        bus.hit = 1'b1;
        chk("mulw_done", 32'(done), 32'd1);
        chk("mulw_edges", 32'(edges), 32'd36);
        chk("mulw_res", bus.ALUResultOut, 32'hFFFFFFFE);

        // Reset at count == 10 aborts the multiply
        drive_mult(32'd7, 32'd9);
        for (int c = 1; c <= 11; c++) begin
            @(posedge clock);
            #1;
        end
        chk("mulr_stall_before", 32'(bus.stallOut), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_zero("mul_rst");
        @(negedge clock);
        reset = 1'b0;
        drive(vecs[0]);
        #1;
        chk("after_rst_stall", 32'(bus.stallOut), 32'd0);
        @(posedge clock);
        #1;
        chk("after_rst_res", bus.ALUResultOut, 32'd19);
        chk("after_rst_ctrl", 32'(ctrl_out()), 32'(vecs[0].ctrl));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
